// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
package riscv_pkg;
  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;
  localparam int PC_INC  = 4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH x WIDTH synchronous FIFO with flush and occupancy count; head is read combinationally.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Flush beats a same-cycle push: that entry belongs to the stream being discarded.
  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    do_push  = push && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && !do_pop && cnt_q == CW'(DEPTH)));
endmodule

// File: rtl/riscv_fetch_unit.sv
// Prefetching instruction fetch stage: credit-limited request issue, in-order response
// buffering, and redirect handling that flushes the buffer and kills in-flight fetches.
module riscv_fetch_unit #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic                          CLK,
  input  logic                          Reset,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [XLEN-1:0]               imem_req_addr,
  input  logic                          imem_rsp_valid,
  input  logic [riscv_pkg::INSTR_W-1:0] imem_rsp_data,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [riscv_pkg::INSTR_W-1:0] instr,
  output logic [XLEN-1:0]               instr_pc,
  output logic [XLEN-1:0]               instr_pc_plus4
);
  import riscv_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = INSTR_W + XLEN;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outst_q, outst_d, kill_q, kill_d;
  logic [CW-1:0]   buf_cnt, pcq_cnt;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] rsp_pc, pc_head;
  logic [BW-1:0]   head;
  logic            req_fire, rsp_keep, pop;

  // Every slot is either in flight or sitting in the buffer, so the buffer can never overflow.
  assign credit_used    = {1'b0, outst_q} + {1'b0, buf_cnt};
  assign imem_req_valid = Reset && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (kill_q == '0);

  assign instr_valid    = (buf_cnt != '0);
  assign pop            = instr_valid && instr_ready;
  assign pc_head        = head[XLEN-1:0];
  assign instr          = instr_valid ? head[BW-1 -: INSTR_W] : '0;
  assign instr_pc       = instr_valid ? pc_head : '0;
  assign instr_pc_plus4 = instr_pc + XLEN'(PC_INC);

  // Kill is loaded with the post-update outstanding count so a request accepted in the
  // redirect cycle is also discarded when it returns.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
    if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);
    if (imem_rsp_valid && kill_q != '0) kill_d = kill_q - 1'b1;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
      kill_d     = outst_d;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      kill_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      kill_q     <= kill_d;
    end
  end

  // Request PCs ride alongside the memory so each response can be tagged; never flushed.
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_pc_q (
    .clk   (CLK),
    .rst_n (Reset),
    .flush (1'b0),
    .push  (req_fire),
    .wdata (imem_req_addr),
    .pop   (imem_rsp_valid),
    .rdata (rsp_pc),
    .count (pcq_cnt)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(BW)) u_ibuf (
    .clk   (CLK),
    .rst_n (Reset),
    .flush (redirect_valid),
    .push  (rsp_keep),
    .wdata ({imem_rsp_data, rsp_pc}),
    .pop   (pop),
    .rdata (head),
    .count (buf_cnt)
  );

  a_pcq_tracks: assert property (@(posedge CLK) disable iff (!Reset) pcq_cnt == outst_q);
  a_rsp_expected: assert property (@(posedge CLK) disable iff (!Reset)
    imem_rsp_valid |-> outst_q != '0);
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit with a latency-configurable memory model.
module tb_riscv_fetch_unit;
  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc, instr_pc_plus4;

  logic        req_valid2;
  logic [31:0] req_addr2, instr2, instr_pc2, instr_pc_plus42;
  logic        instr_valid2;
  logic        ready2 = 1'b1, rsp_valid2 = 1'b0, redir2 = 1'b0, iready2 = 1'b0;
  logic [31:0] rsp_data2 = '0, redir_pc2 = '0;

  riscv_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
    .CLK(CLK), .Reset(Reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4)
  );

  riscv_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(4)) dut_wrap (
    .CLK(CLK), .Reset(Reset),
    .imem_req_valid(req_valid2), .imem_req_ready(ready2), .imem_req_addr(req_addr2),
    .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
    .redirect_valid(redir2), .redirect_pc(redir_pc2),
    .instr_valid(instr_valid2), .instr_ready(iready2), .instr(instr2),
    .instr_pc(instr_pc2), .instr_pc_plus4(instr_pc_plus42)
  );

  always #5 CLK = ~CLK;

  typedef struct { int due; logic [31:0] addr; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; logic [31:0] p4; } pop_t;

  int          checks = 0, failures = 0;
  int          mem_lat = 1;
  int          pcnt = 0;
  mreq_t       mq[$];
  logic [31:0] issue_log[$];
  logic [31:0] issue2_log[$];
  pop_t        pop_log[$];

  // Posedge: record handshakes using pre-edge values.
  always @(posedge CLK) begin
    pcnt++;
    if (Reset) begin
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back('{pcnt + mem_lat, imem_req_addr});
        issue_log.push_back(imem_req_addr);
      end
      if (instr_valid && instr_ready) pop_log.push_back('{instr_pc, instr, instr_pc_plus4});
      if (req_valid2 && ready2) issue2_log.push_back(req_addr2);
    end
  end

  // Negedge: present a response so it is sampled exactly mem_lat edges after acceptance.
  always @(negedge CLK) begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (!Reset) mq.delete();
    else if (mq.size() > 0 && mq[0].due == pcnt + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hC0DE_0000 | {16'h0, mq[0].addr[15:0]};
      void'(mq.pop_front());
    end
  end

  task automatic do_reset(input int lat, input logic ir);
    @(negedge CLK);
    Reset = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    mem_lat = lat;
    repeat (2) @(negedge CLK);
    issue_log.delete();
    issue2_log.delete();
    pop_log.delete();
    instr_ready = ir;
    Reset = 1'b1;
  endtask

  task automatic wait_issue(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (issue_log.size() >= n) ok = 1'b1;
      else @(negedge CLK);
    end
  endtask

  task automatic wait_pop(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (pop_log.size() >= n) ok = 1'b1;
      else @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    imem_req_ready = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge CLK);
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got %b want 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr got %h want 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr_pc got %h want 0", instr_pc); end
    checks++; if (req_addr2 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL reset_pc_param got %h want fffffffc", req_addr2); end
  endtask

  task automatic test_basic;
    do_reset(1, 1'b1);
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin failures++; $display("FAIL basic_first_req got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
    @(negedge CLK);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL basic_no_bypass got %b want 0", instr_valid); end
    @(negedge CLK);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_pc_plus4 !== 32'h4 || instr !== 32'hC0DE_0000) begin
      failures++; $display("FAIL basic_first_instr got v=%b pc=%h p4=%h i=%h want 1 0 4 c0de0000", instr_valid, instr_pc, instr_pc_plus4, instr); end
    repeat (12) @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      checks++; if (issue_log.size() <= i || issue_log[i] !== 32'(4*i)) begin failures++; $display("FAIL basic_addr[%0d] got %h want %h", i, (issue_log.size() > i) ? issue_log[i] : 32'hX, 32'(4*i)); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (pop_log.size() <= i || pop_log[i].pc !== 32'(4*i) || pop_log[i].ins !== (32'hC0DE_0000 | 32'(4*i))) begin
        failures++; $display("FAIL basic_pop[%0d] got pc=%h want %h", i, (pop_log.size() > i) ? pop_log[i].pc : 32'hX, 32'(4*i)); end
    end
  endtask

  task automatic test_backpressure;
    do_reset(1, 1'b0);
    repeat (12) @(negedge CLK);
    checks++; if (issue_log.size() !== 4) begin failures++; $display("FAIL bp_issue_count got %0d want 4", issue_log.size()); end
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_stalled got %b want 0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin failures++; $display("FAIL bp_head got v=%b pc=%h want 1 0", instr_valid, instr_pc); end
    instr_ready = 1'b1;
    @(negedge CLK);
    instr_ready = 1'b0;
    repeat (6) @(negedge CLK);
    checks++; if (issue_log.size() !== 5) begin failures++; $display("FAIL bp_one_more got %0d want 5", issue_log.size()); end
    checks++; if (issue_log.size() < 5 || issue_log[4] !== 32'h10) begin failures++; $display("FAIL bp_next_addr got %h want 10", (issue_log.size() > 4) ? issue_log[4] : 32'hX); end
    checks++; if (imem_req_valid !== 1'b0 || instr_pc !== 32'h4) begin failures++; $display("FAIL bp_after_pop got v=%b pc=%h want 0 4", imem_req_valid, instr_pc); end
  endtask

  task automatic test_redirect_inflight;
    bit ok;
    do_reset(3, 1'b1);
    wait_issue(3, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rd3_wait got timeout want 3 issues"); end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge CLK);
    redirect_valid = 1'b0;
    checks++; if (imem_req_addr !== 32'h100 || instr_valid !== 1'b0) begin failures++; $display("FAIL rd3_after got a=%h v=%b want 100 0", imem_req_addr, instr_valid); end
    wait_pop(2, ok);
    checks++; if (!ok || pop_log[0].pc !== 32'h100 || pop_log[0].ins !== 32'hC0DE_0100) begin failures++; $display("FAIL rd3_first got pc=%h want 100", (pop_log.size() > 0) ? pop_log[0].pc : 32'hX); end
    checks++; if (!ok || pop_log[1].pc !== 32'h104) begin failures++; $display("FAIL rd3_second got pc=%h want 104", (pop_log.size() > 1) ? pop_log[1].pc : 32'hX); end
  endtask

  task automatic test_redirect_collide;
    bit ok;
    do_reset(2, 1'b1);
    wait_issue(2, ok);
    checks++; if (!ok || imem_req_valid !== 1'b1) begin failures++; $display("FAIL col_pre got v=%b want 1", imem_req_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge CLK);
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req_addr !== 32'h40) begin failures++; $display("FAIL col_flush got v=%b a=%h want 0 40", instr_valid, imem_req_addr); end
    wait_pop(2, ok);
    checks++; if (issue_log.size() < 4 || issue_log[2] !== 32'h8 || issue_log[3] !== 32'h40) begin failures++; $display("FAIL col_issue got %h/%h want 8/40", (issue_log.size() > 2) ? issue_log[2] : 32'hX, (issue_log.size() > 3) ? issue_log[3] : 32'hX); end
    checks++; if (!ok || pop_log[0].pc !== 32'h40 || pop_log[1].pc !== 32'h44) begin failures++; $display("FAIL col_pops got %h/%h want 40/44", (pop_log.size() > 0) ? pop_log[0].pc : 32'hX, (pop_log.size() > 1) ? pop_log[1].pc : 32'hX); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    do_reset(3, 1'b1);
    wait_issue(1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_wait got timeout want 1 issue"); end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    @(negedge CLK);
    redirect_pc = 32'h300;
    @(negedge CLK);
    redirect_valid = 1'b0;
    checks++; if (imem_req_addr !== 32'h300) begin failures++; $display("FAIL b2b_pc got %h want 300", imem_req_addr); end
    wait_pop(1, ok);
    checks++; if (!ok || pop_log[0].pc !== 32'h300 || pop_log[0].ins !== 32'hC0DE_0300) begin failures++; $display("FAIL b2b_first got pc=%h want 300", (pop_log.size() > 0) ? pop_log[0].pc : 32'hX); end
    checks++; if (issue_log.size() < 4 || issue_log[2] !== 32'h80 || issue_log[3] !== 32'h300) begin failures++; $display("FAIL b2b_issue got %h/%h want 80/300", (issue_log.size() > 2) ? issue_log[2] : 32'hX, (issue_log.size() > 3) ? issue_log[3] : 32'hX); end
  endtask

  task automatic test_align;
    bit ok;
    do_reset(1, 1'b1);
    repeat (6) @(negedge CLK);
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    @(negedge CLK);
    redirect_valid = 1'b0;
    pop_log.delete();
    checks++; if (imem_req_addr !== 32'h200) begin failures++; $display("FAIL align_addr got %h want 200", imem_req_addr); end
    wait_pop(2, ok);
    checks++; if (!ok || pop_log[0].pc !== 32'h200 || pop_log[0].p4 !== 32'h204 || pop_log[0].ins !== 32'hC0DE_0200) begin
      failures++; $display("FAIL align_pop got pc=%h p4=%h want 200 204", (pop_log.size() > 0) ? pop_log[0].pc : 32'hX, (pop_log.size() > 0) ? pop_log[0].p4 : 32'hX); end
    checks++; if (!ok || pop_log[1].pc !== 32'h204) begin failures++; $display("FAIL align_pop2 got %h want 204", (pop_log.size() > 1) ? pop_log[1].pc : 32'hX); end
  endtask

  task automatic test_wrap;
    do_reset(1, 1'b0);
    repeat (8) @(negedge CLK);
    checks++; if (issue2_log.size() !== 4) begin failures++; $display("FAIL wrap_count got %0d want 4", issue2_log.size()); end
    checks++; if (issue2_log.size() < 4 || issue2_log[0] !== 32'hFFFF_FFFC || issue2_log[1] !== 32'h0 || issue2_log[2] !== 32'h4 || issue2_log[3] !== 32'h8) begin
      failures++; $display("FAIL wrap_addrs got %h %h want fffffffc 0", (issue2_log.size() > 0) ? issue2_log[0] : 32'hX, (issue2_log.size() > 1) ? issue2_log[1] : 32'hX); end
    checks++; if (req_valid2 !== 1'b0) begin failures++; $display("FAIL wrap_stall got %b want 0", req_valid2); end
  endtask

  task automatic test_reset_midstream;
    bit ok;
    do_reset(1, 1'b0);
    repeat (10) @(negedge CLK);
    checks++; if (instr_valid !== 1'b1 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL mid_full got v=%b rq=%b want 1 0", instr_valid, imem_req_valid); end
    Reset = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || instr_pc !== 32'h0 || instr !== 32'h0) begin failures++; $display("FAIL mid_async_full got v=%b pc=%h want 0 0", instr_valid, instr_pc); end
    do_reset(1, 1'b1);
    repeat (5) @(negedge CLK);
    checks++; if (imem_req_valid !== 1'b1 || instr_valid !== 1'b1) begin failures++; $display("FAIL mid_stream got rq=%b v=%b want 1 1", imem_req_valid, instr_valid); end
    Reset = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL mid_async_stream got rq=%b v=%b want 0 0", imem_req_valid, instr_valid); end
    do_reset(1, 1'b1);
    #1;
    checks++; if (imem_req_addr !== 32'h0 || imem_req_valid !== 1'b1) begin failures++; $display("FAIL mid_restart got a=%h v=%b want 0 1", imem_req_addr, imem_req_valid); end
    wait_pop(1, ok);
    checks++; if (!ok || pop_log[0].pc !== 32'h0) begin failures++; $display("FAIL mid_restart_pop got %h want 0", (pop_log.size() > 0) ? pop_log[0].pc : 32'hX); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collide();
    test_back_to_back();
    test_align();
    test_wrap();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
